// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: HLT opcode, fetch FSM state encodings and
// the helper that recognises a HLT instruction word.
package fetch_unit_pkg;

   localparam logic [3:0] OPCODE_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4
   } fetch_state_e;

   function automatic logic is_hlt(input logic [3:0] opcode);
      return opcode == OPCODE_HLT;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read channel plus the
// valid/ready output slot towards decode.
interface fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              id_valid;
   logic              id_ready;
   logic [DATA_W-1:0] id_instr;
   logic [ADDR_W-1:0] id_pc;

   modport master (
      output mem_req, mem_addr, id_valid, id_instr, id_pc,
      input  mem_ready, mem_rvalid, mem_rdata, id_ready
   );

   modport slave (
      input  mem_req, mem_addr, id_valid, id_instr, id_pc,
      output mem_ready, mem_rvalid, mem_rdata, id_ready
   );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that parks a returned word while
// decode is back-pressuring the output slot.
module fetch_skid_buf #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              unload_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              full_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] pc_o
);
   logic              full_q, full_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      full_d  = full_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (load_i) begin
         full_d  = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (unload_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q  <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         full_q  <= full_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding memory read per PC, output slot
// plus skid buffer towards decode, wrong-path discard and HLT parking.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pc_redirect_i,
   fetch_unit_if.master      bus,
   output logic              stall_o,
   output logic              halted_o
);
   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              drop_q, drop_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;

   logic              skid_load, skid_unload, skid_clear, skid_full;
   logic [DATA_W-1:0] skid_instr;
   logic [ADDR_W-1:0] skid_pc;
   logic              slot_free, mem_acc;

   fetch_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .instr_i  (bus.mem_rdata),
      .pc_i     (req_pc_q),
      .full_o   (skid_full),
      .instr_o  (skid_instr),
      .pc_o     (skid_pc)
   );

   assign slot_free = ~out_valid_q | bus.id_ready;
   assign mem_acc   = (state_q == ST_REQ) & bus.mem_ready;

   always_comb begin
      state_d     = state_q;
      req_pc_d    = req_pc_q;
      drop_d      = drop_q;
      out_valid_d = out_valid_q & ~bus.id_ready;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = pc_redirect_i & (state_q != ST_HALTED);

      unique case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (bus.mem_ready) begin
               req_pc_d = pc_i;
               // The PC shown alongside a redirect is wrong-path.
               drop_d   = pc_redirect_i;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mem_rvalid) begin
               drop_d = 1'b0;
               if (drop_q || pc_redirect_i) begin
                  state_d = ST_REQ;
               end else if (slot_free) begin
                  out_valid_d = 1'b1;
                  out_instr_d = bus.mem_rdata;
                  out_pc_d    = req_pc_q;
                  state_d     = is_hlt(bus.mem_rdata[DATA_W-1 -: 4]) ? ST_HALTED : ST_REQ;
               end else begin
                  skid_load = 1'b1;
                  state_d   = ST_HOLD;
               end
            end else if (pc_redirect_i) begin
               drop_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (pc_redirect_i) begin
               state_d = ST_REQ;
            end else if (bus.id_ready) begin
               skid_unload = 1'b1;
               out_valid_d = 1'b1;
               out_instr_d = skid_instr;
               out_pc_d    = skid_pc;
               state_d     = is_hlt(skid_instr[DATA_W-1 -: 4]) ? ST_HALTED : ST_REQ;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         req_pc_q    <= '0;
         drop_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_instr_q <= NOP_INSTR;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_pc_q    <= req_pc_d;
         drop_q      <= drop_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign bus.mem_req  = (state_q == ST_REQ);
   assign bus.mem_addr = pc_i;
   assign bus.id_valid = out_valid_q;
   assign bus.id_instr = out_valid_q ? out_instr_q : NOP_INSTR;
   assign bus.id_pc    = out_pc_q;
   assign stall_o      = ~mem_acc;
   assign halted_o     = (state_q == ST_HALTED);

   // The skid is only ever filled from WAIT and drained back to REQ, so a
   // full skid outside HOLD would mean a lost word.
   logic unused_full;
   assign unused_full = skid_full;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: models pc_register and a latency-
// programmable instruction memory, predicts delivered words in order.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc = 16'h0000;
   logic        pc_redirect = 1'b0;
   logic        stall, halted;

   fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   fetch_unit #(.ADDR_W(16), .DATA_W(16), .NOP_INSTR(16'h0000)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pc_i          (pc),
      .pc_redirect_i (pc_redirect),
      .bus           (bus),
      .stall_o       (stall),
      .halted_o      (halted)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0, n_err = 0, n_cons = 0;
   logic [31:0] sb_q[$];
   int          lat = 1;
   logic [15:0] redir_tgt = 16'h0000;
   bit          halt_en = 1'b0;
   bit          pend = 1'b0, pend_dead = 1'b0;
   int          pend_cnt = 0;
   logic [15:0] pend_addr = 16'h0000;
   logic [15:0] last_cpc = 16'h0000, last_cinstr = 16'h0000;
   logic        o_req, o_stall, o_acc, o_rvalid, o_idv, o_halt;
   logic [15:0] o_addr, o_idpc, o_instr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] memfn(input logic [15:0] a);
      if (halt_en && a == 16'h0010) return 16'hF000;
      return {4'h1, a[11:0] ^ 12'h5A0};
   endfunction

   // One clock: observe at negedge, then advance PC and memory after the edge.
   task automatic step();
      logic [31:0] e;
      @(negedge clk);
      o_req    = bus.mem_req;
      o_stall  = stall;
      o_acc    = bus.mem_req & bus.mem_ready;
      o_rvalid = bus.mem_rvalid;
      o_idv    = bus.id_valid;
      o_halt   = halted;
      o_addr   = bus.mem_addr;
      o_idpc   = bus.id_pc;
      o_instr  = bus.id_instr;
      if (rst) begin
         sb_q.delete();
         pend_dead = 1'b1;
         o_acc = 1'b0;
      end else begin
         if (o_idv && bus.id_ready) begin
            n_cons++;
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk("id_instr", {16'h0, o_instr}, {16'h0, e[31:16]});
               chk("id_pc", {16'h0, o_idpc}, {16'h0, e[15:0]});
               last_cpc    = o_idpc;
               last_cinstr = o_instr;
            end
         end
         if (pend && pc_redirect) pend_dead = 1'b1;
         if (bus.mem_rvalid && pend) begin
            if (!pend_dead) sb_q.push_back({bus.mem_rdata, pend_addr});
            pend = 1'b0;
         end
         if (o_acc) begin
            chk("mem_addr", {16'h0, o_addr}, {16'h0, pc});
            pend      = 1'b1;
            pend_dead = pc_redirect;
            pend_cnt  = lat;
            pend_addr = o_addr;
         end
      end
      @(posedge clk);
      #1;
      if (rst)              pc = 16'h0000;
      else if (pc_redirect) pc = redir_tgt;
      else if (o_acc)       pc = pc + 16'd2;
      pc_redirect = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'hDEAD;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = memfn(pend_addr);
         end
      end
   endtask

   task automatic wait_acc(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!o_acc && n < 60);
      chk(tag, 32'(o_acc), 32'd1);
   endtask

   initial begin
      logic [7:0] sp;
      int         c0, bad, n;
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'h0000;
      bus.id_ready   = 1'b1;
      rst = 1'b1;
      step();
      step();
      chk("rst_mem_req", 32'(o_req), 32'd0);
      chk("rst_id_valid", 32'(o_idv), 32'd0);
      chk("rst_id_instr", {16'h0, o_instr}, 32'h0000);
      chk("rst_id_pc", {16'h0, o_idpc}, 32'h0000);
      chk("rst_stall", 32'(o_stall), 32'd1);
      chk("rst_halted", 32'(o_halt), 32'd0);

      // 1: zero-wait memory, one instruction every two cycles
      rst = 1'b0;
      sp = '0;
      c0 = n_cons;
      for (int i = 0; i < 8; i++) begin
         step();
         sp[i] = o_stall;
      end
      chk("t1_stall_pat", {24'h0, sp}, 32'h55);
      chk("t1_deliveries", 32'(n_cons - c0), 32'd3);
      chk("t1_last_pc", {16'h0, last_cpc}, 32'h0004);

      // 2: decode back-pressure parks the second word in the skid
      bus.id_ready = 1'b0;
      repeat (5) step();
      chk("t2_held", 32'(sb_q.size()), 32'd2);
      chk("t2_mem_req", 32'(o_req), 32'd0);
      chk("t2_stall", 32'(o_stall), 32'd1);
      bus.id_ready = 1'b1;
      repeat (6) step();
      chk("t2_drain_pc", {16'h0, last_cpc}, 32'h000C);

      // 3: redirect while a fetch is outstanding
      lat = 3;
      wait_acc("t3_acc");
      pc_redirect = 1'b1;
      redir_tgt = 16'h0040;
      step();
      chk("t3_no_rv", 32'(o_rvalid), 32'd0);
      wait_acc("t3_acc2");
      chk("t3_addr", {16'h0, o_addr}, 32'h0040);
      repeat (4) step();
      chk("t3_pc", {16'h0, last_cpc}, 32'h0040);

      // 4: redirect coincident with rvalid
      lat = 2;
      wait_acc("t4_acc");
      step();
      pc_redirect = 1'b1;
      redir_tgt = 16'h0080;
      step();
      chk("t4_rv", 32'(o_rvalid), 32'd1);
      wait_acc("t4_acc2");
      chk("t4_addr", {16'h0, o_addr}, 32'h0080);
      repeat (3) step();
      chk("t4_pc", {16'h0, last_cpc}, 32'h0080);

      // 6: reset mid-fetch with a late response
      lat = 4;
      wait_acc("t6_acc");
      rst = 1'b1;
      bus.mem_ready = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("t6_mem_req", 32'(o_req), 32'd0);
      chk("t6_id_valid", 32'(o_idv), 32'd0);
      chk("t6_id_instr", {16'h0, o_instr}, 32'h0000);
      chk("t6_id_pc", {16'h0, o_idpc}, 32'h0000);
      chk("t6_stall", 32'(o_stall), 32'd1);
      chk("t6_halted", 32'(o_halt), 32'd0);
      step();
      step();
      chk("t6_stale_rv", 32'(o_rvalid), 32'd1);
      step();
      chk("t6_stale_idv", 32'(o_idv), 32'd0);
      bus.mem_ready = 1'b1;
      lat = 1;
      wait_acc("t6_acc2");
      chk("t6_addr", {16'h0, o_addr}, 32'h0000);

      // 5: HLT at 0x0010 parks the stage
      halt_en = 1'b1;
      lat = 2;
      pc_redirect = 1'b1;
      redir_tgt = 16'h0010;
      step();
      n = 0;
      do begin
         step();
         n++;
      end while (!o_halt && n < 40);
      chk("t5_halted", 32'(o_halt), 32'd1);
      bad = 0;
      repeat (20) begin
         step();
         if (o_req || !o_stall || !o_halt) bad++;
      end
      chk("t5_parked", 32'(bad), 32'd0);
      chk("t5_pc", {16'h0, last_cpc}, 32'h0010);
      chk("t5_instr", {16'h0, last_cinstr}, 32'hF000);
      chk("t5_idv", 32'(o_idv), 32'd0);
      chk("t5_nop", {16'h0, o_instr}, 32'h0000);
      chk("sb_left", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
